// File: rtl/dmem_responder.sv
// dmem_responder: memory-side responder for CPU load/store traffic.
//
// Accepts one request at a time on a valid/ready request channel and services it against an
// internal word array after WAIT_CYCLES wait states. Read data and error status come back on a
// valid/ready response channel. err_flag is a sticky record of any errored request since reset.
//
// Optional feature macro: DMEM_RESP_WRITE_ACK_EN
//   defined   - stores produce a response like loads (rsp_rdata = 0, rsp_err as computed)
//   undefined - stores commit and return straight to idle; store errors only reach err_flag
//
// Ports:
//   clk, rst            clock, synchronous active-high reset (array contents are kept)
//   req_valid/req_ready request handshake
//   req_we              1 = store, 0 = load
//   req_addr            byte address (must be word aligned and below DEPTH*4)
//   req_wdata, req_be   store data and byte-lane enables
//   rsp_valid/rsp_ready response handshake
//   rsp_rdata, rsp_err  load data (0 for stores/errors) and error status, stable while rsp_valid
//   err_flag            sticky error indicator, cleared only by rst

module dmem_responder #(
  parameter int unsigned DEPTH       = 32,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        err_flag
);

  localparam int unsigned IdxW     = $clog2(DEPTH);
  localparam logic [31:0] AddrLimit = 32'(DEPTH * 4);
  localparam logic [3:0]  WaitInit  = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StWait = 2'd1;
  localparam logic [1:0] StResp = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;

  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;

  logic [31:0] rsp_rdata_q;
  logic        rsp_err_q;
  logic        err_flag_q;

  logic [31:0] mem [DEPTH];

  logic            accept;
  logic            commit;
  logic            c_we;
  logic [31:0]     c_addr;
  logic [31:0]     c_wdata;
  logic [3:0]      c_be;
  logic            c_err;
  logic [IdxW-1:0] c_idx;
  logic            c_rsp;

  assign accept = (state_q == StIdle) && req_valid;

  // With no wait states the commit happens on the accept edge using the live request; otherwise
  // it happens on the last wait edge using the latched copy.
  assign commit = (WAIT_CYCLES == 0) ? accept : ((state_q == StWait) && (cnt_q == 4'd0));

  assign c_we    = (state_q == StIdle) ? req_we    : we_q;
  assign c_addr  = (state_q == StIdle) ? req_addr  : addr_q;
  assign c_wdata = (state_q == StIdle) ? req_wdata : wdata_q;
  assign c_be    = (state_q == StIdle) ? req_be    : be_q;

  assign c_err = (c_addr[1:0] != 2'b00) || (c_addr >= AddrLimit);
  assign c_idx = c_addr[IdxW+1:2];

`ifdef DMEM_RESP_WRITE_ACK_EN
  assign c_rsp = 1'b1;
`else
  assign c_rsp = ~c_we;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          if (WAIT_CYCLES == 0) begin
            state_d = c_rsp ? StResp : StIdle;
          end else begin
            state_d = StWait;
            cnt_d   = WaitInit;
          end
        end
      end
      StWait: begin
        if (cnt_q == 4'd0) begin
          state_d = c_rsp ? StResp : StIdle;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= 4'd0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
      err_flag_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (commit && c_rsp) begin
        rsp_rdata_q <= (c_we || c_err) ? 32'd0 : mem[c_idx];
        rsp_err_q   <= c_err;
      end else if ((state_q == StResp) && rsp_ready) begin
        rsp_rdata_q <= 32'd0;
        rsp_err_q   <= 1'b0;
      end
      if (commit && c_err) begin
        err_flag_q <= 1'b1;
      end
    end
  end

  // Request capture needs no reset: the copy is only consumed after a fresh accept.
  always_ff @(posedge clk) begin
    if (accept) begin
      we_q    <= req_we;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      be_q    <= req_be;
    end
  end

  // rst suppresses the write so an aborted store never lands.
  always_ff @(posedge clk) begin
    if (!rst && commit && c_we && !c_err) begin
      for (int b = 0; b < 4; b++) begin
        if (c_be[b]) begin
          mem[c_idx][8*b +: 8] <= c_wdata[8*b +: 8];
        end
      end
    end
  end

  assign req_ready = (state_q == StIdle);
  assign rsp_valid = (state_q == StResp);
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign err_flag  = err_flag_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (no wait states / three wait states) driven by
// directed sequences and random traffic, checked every cycle against a cycle-count model.

module tb_dmem_responder;

  localparam int unsigned D0 = 32;
  localparam int unsigned D1 = 16;
  localparam int unsigned W0 = 0;
  localparam int unsigned W1 = 3;

`ifdef DMEM_RESP_WRITE_ACK_EN
  localparam bit Ack = 1'b1;
`else
  localparam bit Ack = 1'b0;
`endif

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst       [2];
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_we    [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic [3:0]  req_be    [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_err   [2];
  logic        err_flag  [2];

  dmem_responder #(.DEPTH(D0), .WAIT_CYCLES(W0)) u_dut0 (
    .clk       (clk),
    .rst       (rst[0]),
    .req_valid (req_valid[0]),
    .req_ready (req_ready[0]),
    .req_we    (req_we[0]),
    .req_addr  (req_addr[0]),
    .req_wdata (req_wdata[0]),
    .req_be    (req_be[0]),
    .rsp_valid (rsp_valid[0]),
    .rsp_ready (rsp_ready[0]),
    .rsp_rdata (rsp_rdata[0]),
    .rsp_err   (rsp_err[0]),
    .err_flag  (err_flag[0])
  );

  dmem_responder #(.DEPTH(D1), .WAIT_CYCLES(W1)) u_dut1 (
    .clk       (clk),
    .rst       (rst[1]),
    .req_valid (req_valid[1]),
    .req_ready (req_ready[1]),
    .req_we    (req_we[1]),
    .req_addr  (req_addr[1]),
    .req_wdata (req_wdata[1]),
    .req_be    (req_be[1]),
    .rsp_valid (rsp_valid[1]),
    .rsp_ready (rsp_ready[1]),
    .rsp_rdata (rsp_rdata[1]),
    .rsp_err   (rsp_err[1]),
    .err_flag  (err_flag[1])
  );

  int checks = 0;
  int errors = 0;
  int unsigned ecount = 0;

  // Model: a transaction is described by its accept edge and its commit edge (accept + wait).
  bit          m_busy      [2];
  bit          m_comm      [2];
  bit          m_flag      [2];
  bit          m_err       [2];
  int unsigned m_commit_at [2];
  logic        m_we        [2];
  logic [31:0] m_addr      [2];
  logic [31:0] m_wdata     [2];
  logic [3:0]  m_be        [2];
  logic [31:0] m_rdata     [2];
  logic [31:0] m_mem       [2][32];

  function automatic int unsigned depth_of(input int i);
    return (i == 0) ? D0 : D1;
  endfunction

  function automatic int unsigned wait_of(input int i);
    return (i == 0) ? W0 : W1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_commit(input int i);
    bit err;
    int idx;
    err = (m_addr[i][1:0] != 2'b00) || (m_addr[i] >= 32'(depth_of(i) * 4));
    idx = int'(m_addr[i] >> 2);
    m_err[i]   = err;
    m_rdata[i] = 32'd0;
    if (err) m_flag[i] = 1'b1;
    else if (m_we[i]) begin
      for (int b = 0; b < 4; b++)
        if (m_be[i][b]) m_mem[i][idx][8*b +: 8] = m_wdata[i][8*b +: 8];
    end else m_rdata[i] = m_mem[i][idx];
    if (m_we[i] && !Ack) m_busy[i] = 1'b0;
    else m_comm[i] = 1'b1;
  endtask

  task automatic model_edge(input int i);
    if (rst[i]) begin
      m_busy[i] = 1'b0;
      m_comm[i] = 1'b0;
      m_flag[i] = 1'b0;
    end else if (m_busy[i] && m_comm[i]) begin
      if (rsp_ready[i]) begin
        m_busy[i] = 1'b0;
        m_comm[i] = 1'b0;
      end
    end else if (m_busy[i]) begin
      if (ecount == m_commit_at[i]) model_commit(i);
    end else if (req_valid[i]) begin
      m_we[i]        = req_we[i];
      m_addr[i]      = req_addr[i];
      m_wdata[i]     = req_wdata[i];
      m_be[i]        = req_be[i];
      m_busy[i]      = 1'b1;
      m_comm[i]      = 1'b0;
      m_commit_at[i] = ecount + wait_of(i);
      if (wait_of(i) == 0) model_commit(i);
    end
  endtask

  task automatic compare(input int i);
    chk($sformatf("req_ready%0d", i), 32'(req_ready[i]), 32'(!m_busy[i]));
    chk($sformatf("rsp_valid%0d", i), 32'(rsp_valid[i]), 32'(m_busy[i] && m_comm[i]));
    chk($sformatf("err_flag%0d", i), 32'(err_flag[i]), 32'(m_flag[i]));
    if (m_busy[i] && m_comm[i]) begin
      chk($sformatf("rsp_rdata%0d", i), rsp_rdata[i], m_rdata[i]);
      chk($sformatf("rsp_err%0d", i), 32'(rsp_err[i]), 32'(m_err[i]));
    end
  endtask

  // One clock: model follows the edge, outputs are compared on the falling edge.
  task automatic tick();
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    ecount++;
    @(negedge clk);
    compare(0);
    compare(1);
  endtask

  task automatic issue(input int i, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be);
    chk("issue_ready", 32'(req_ready[i]), 32'd1);
    req_we[i]    = we;
    req_addr[i]  = addr;
    req_wdata[i] = wdata;
    req_be[i]    = be;
    req_valid[i] = 1'b1;
    tick();
    req_valid[i] = 1'b0;
  endtask

  task automatic wait_rsp(input int i);
    int n;
    n = 0;
    while (!rsp_valid[i] && n < 20) begin
      tick();
      n++;
    end
    chk("rsp_wait", 32'(rsp_valid[i]), 32'd1);
  endtask

  task automatic wait_ready(input int i);
    int n;
    n = 0;
    while (!req_ready[i] && n < 20) begin
      tick();
      n++;
    end
    chk("ready_wait", 32'(req_ready[i]), 32'd1);
  endtask

  task automatic take_rsp(input int i);
    rsp_ready[i] = 1'b1;
    tick();
    rsp_ready[i] = 1'b0;
  endtask

  task automatic store(input int i, input logic [31:0] addr, input logic [31:0] data,
                       input logic [3:0] be);
    issue(i, 1'b1, addr, data, be);
`ifdef DMEM_RESP_WRITE_ACK_EN
    wait_rsp(i);
    take_rsp(i);
`else
    wait_ready(i);
`endif
  endtask

  task automatic load(input int i, input logic [31:0] addr, input string name,
                      input logic [31:0] exp_data, input logic exp_err);
    issue(i, 1'b0, addr, 32'd0, 4'h0);
    wait_rsp(i);
    chk({name, "_rdata"}, rsp_rdata[i], exp_data);
    chk({name, "_err"}, 32'(rsp_err[i]), 32'(exp_err));
    take_rsp(i);
  endtask

  task automatic randomize_inputs(input int i);
    int unsigned r;
    int unsigned d;
    d = depth_of(i);
    r = $urandom_range(0, 9);
    if (r < 7) req_addr[i] = 32'($urandom_range(0, d - 1)) << 2;
    else if (r == 7) req_addr[i] = (32'($urandom_range(0, d - 1)) << 2) | 32'($urandom_range(1, 3));
    else if (r == 8) req_addr[i] = 32'(d * 4);
    else req_addr[i] = $urandom;
    rst[i]       = ($urandom_range(0, 199) == 0);
    req_valid[i] = ($urandom_range(0, 9) < 6);
    req_we[i]    = 1'($urandom_range(0, 1));
    req_wdata[i] = $urandom;
    req_be[i]    = 4'($urandom_range(0, 15));
    rsp_ready[i] = ($urandom_range(0, 9) < 7);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      rst[i]       = 1'b1;
      req_valid[i] = 1'b0;
      req_we[i]    = 1'b0;
      req_addr[i]  = 32'd0;
      req_wdata[i] = 32'd0;
      req_be[i]    = 4'h0;
      rsp_ready[i] = 1'b0;
      m_busy[i]    = 1'b0;
      m_comm[i]    = 1'b0;
      m_flag[i]    = 1'b0;
    end
    tick();
    tick();
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("rst_ready", 32'(req_ready[i]), 32'd1);
      chk("rst_valid", 32'(rsp_valid[i]), 32'd0);
      chk("rst_rdata", rsp_rdata[i], 32'd0);
      chk("rst_err", 32'(rsp_err[i]), 32'd0);
      chk("rst_flag", 32'(err_flag[i]), 32'd0);
    end

    // Give every word a known value before any load.
    for (int i = 0; i < 2; i++)
      for (int w = 0; w < int'(depth_of(i)); w++)
        store(i, 32'(w * 4), $urandom, 4'hF);

    // Full-word store then load, no wait states.
    issue(0, 1'b1, 32'h08, 32'hDEADBEEF, 4'hF);
`ifdef DMEM_RESP_WRITE_ACK_EN
    chk("t1_ack_valid", 32'(rsp_valid[0]), 32'd1);
    chk("t1_ack_err", 32'(rsp_err[0]), 32'd0);
    chk("t1_ack_rdata", rsp_rdata[0], 32'd0);
    take_rsp(0);
`else
    chk("t1_noack_valid", 32'(rsp_valid[0]), 32'd0);
    chk("t1_noack_ready", 32'(req_ready[0]), 32'd1);
`endif
    issue(0, 1'b0, 32'h08, 32'd0, 4'h0);
    chk("t1_load_valid", 32'(rsp_valid[0]), 32'd1);
    chk("t1_load_rdata", rsp_rdata[0], 32'hDEADBEEF);
    take_rsp(0);

    // Byte lane 1 only.
    store(0, 32'h08, 32'h0000AA00, 4'b0010);
    load(0, 32'h08, "t2_load", 32'hDEADAAEF, 1'b0);

    // Three wait states: response visible on the fourth cycle after accept.
    store(1, 32'h08, 32'h0BADF00D, 4'hF);
    issue(1, 1'b0, 32'h08, 32'd0, 4'h0);
    for (int k = 0; k < 3; k++) begin
      chk("t3_ready_low", 32'(req_ready[1]), 32'd0);
      chk("t3_valid_low", 32'(rsp_valid[1]), 32'd0);
      tick();
    end
    chk("t3_valid", 32'(rsp_valid[1]), 32'd1);
    chk("t3_ready", 32'(req_ready[1]), 32'd0);
    chk("t3_rdata", rsp_rdata[1], 32'h0BADF00D);

    // Backpressure holds the response.
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("t4_valid", 32'(rsp_valid[1]), 32'd1);
      chk("t4_ready", 32'(req_ready[1]), 32'd0);
      chk("t4_rdata", rsp_rdata[1], 32'h0BADF00D);
    end
    take_rsp(1);
    chk("t4_idle_valid", 32'(rsp_valid[1]), 32'd0);
    chk("t4_idle_ready", 32'(req_ready[1]), 32'd1);

    // Errors: misaligned, first out-of-range address, errored store leaves memory alone.
    load(0, 32'h06, "t5_mis", 32'd0, 1'b1);
    chk("t5_flag", 32'(err_flag[0]), 32'd1);
    load(0, 32'(D0 * 4), "t5_oor", 32'd0, 1'b1);
    store(0, 32'h09, 32'hFFFFFFFF, 4'hF);
    load(0, 32'h08, "t5_mem", 32'hDEADAAEF, 1'b0);
    chk("t5_flag_sticky", 32'(err_flag[0]), 32'd1);
    rst[0] = 1'b1;
    tick();
    rst[0] = 1'b0;
    chk("t5_flag_cleared", 32'(err_flag[0]), 32'd0);
    load(0, 32'h08, "t5_mem_after_rst", 32'hDEADAAEF, 1'b0);

    // Reset during the wait of a store discards it.
    store(1, 32'h10, 32'h12345678, 4'hF);
    issue(1, 1'b1, 32'h10, 32'hCAFEF00D, 4'hF);
    tick();
    rst[1] = 1'b1;
    tick();
    rst[1] = 1'b0;
    chk("t6_valid", 32'(rsp_valid[1]), 32'd0);
    chk("t6_ready", 32'(req_ready[1]), 32'd1);
    chk("t6_rdata", rsp_rdata[1], 32'd0);
    load(1, 32'h10, "t6_load", 32'h12345678, 1'b0);

    // Random traffic on both instances at once.
    for (int c = 0; c < 4000; c++) begin
      randomize_inputs(0);
      randomize_inputs(1);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
